dcache_flush_sequencer: RTL

//  Walks every (index, way) of the D-cache on a flush request, writes back valid+dirty lines to memory and

---
 rtl/dcache_flush_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_flush_sequencer.sv
// -----------------------------------------------------------------------------
// dcache_flush_sequencer
//
// Walks every (index, way) of the D-cache when a flush is requested. Each line
// is read through the shared cache-array port. A valid+dirty line is written
// back to memory and then invalidated. A valid clean line is only invalidated.
// An invalid line is skipped with no array write. While the walk is active,
// dcFlushing blocks LSU/MSHR array grants. dcFlushComplete pulses once in the
// final cycle of the walk.
//
// Ports
//   clk              clock; all state changes on the rising edge
//   rst              synchronous reset, active low
//   flushReq         level flush request; sampled only while idle
//   mshrBusy         any MSHR valid; the walk waits for this to clear
//   dcFlushing       high from the accepted request through the DONE cycle
//   dcFlushComplete  one-cycle end-of-flush pulse
//   arrayReq         cache-array port request
//   arrayGrt         port granted; the presented command is consumed
//   arrayWE          1 = invalidate (index, way); 0 = read (index, way)
//   arrayIndex       set index of the command
//   arrayWay         way of the command
//   arrayTagOut      read tag, valid the cycle after a granted read
//   arrayValidOut    read valid bit, same timing as arrayTagOut
//   arrayDirtyOut    read dirty bit, same timing as arrayTagOut
//   arrayDataOut     read line data, same timing as arrayTagOut
//   memReq           memory write-back request
//   memAddr          write-back address {tag, index, zero offset}
//   memData          write-back line data
//   memReqAck        write-back request accepted this cycle
//   memWriteDone     write-back finished
// -----------------------------------------------------------------------------
module dcache_flush_sequencer #(
    parameter int INDEX_BIT_WIDTH  = 8,
    parameter int WAY_NUM          = 2,
    parameter int TAG_WIDTH        = 20,
    parameter int OFFSET_BIT_WIDTH = 4,
    parameter int LINE_WIDTH       = 128,
    localparam int WAY_W  = $clog2(WAY_NUM),
    localparam int ADDR_W = TAG_WIDTH + INDEX_BIT_WIDTH + OFFSET_BIT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flushReq,
    input  logic                       mshrBusy,
    output logic                       dcFlushing,
    output logic                       dcFlushComplete,
    output logic                       arrayReq,
    input  logic                       arrayGrt,
    output logic                       arrayWE,
    output logic [INDEX_BIT_WIDTH-1:0] arrayIndex,
    output logic [WAY_W-1:0]           arrayWay,
    input  logic [TAG_WIDTH-1:0]       arrayTagOut,
    input  logic                       arrayValidOut,
    input  logic                       arrayDirtyOut,
    input  logic [LINE_WIDTH-1:0]      arrayDataOut,
    output logic                       memReq,
    output logic [ADDR_W-1:0]          memAddr,
    output logic [LINE_WIDTH-1:0]      memData,
    input  logic                       memReqAck,
    input  logic                       memWriteDone
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRAIN,
        S_RD,
        S_RD_WAIT,
        S_WB_REQ,
        S_WB_WAIT,
        S_INV,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [INDEX_BIT_WIDTH-1:0] LAST_INDEX = '1;
    localparam logic [INDEX_BIT_WIDTH-1:0] INDEX_ONE  = INDEX_BIT_WIDTH'(1);
    localparam logic [WAY_W-1:0]           LAST_WAY   = WAY_W'(WAY_NUM - 1);
    localparam logic [WAY_W-1:0]           WAY_ONE    = WAY_W'(1);

    state_t                    state_q;
    logic [INDEX_BIT_WIDTH-1:0] index_q;
    logic [WAY_W-1:0]           way_q;
    logic                       flushing_q;
    logic                       complete_q;
    logic                       array_req_q;
    logic                       array_we_q;
    logic                       mem_req_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [LINE_WIDTH-1:0]      mem_data_q;

    logic last_line;
    assign last_line = (index_q == LAST_INDEX) && (way_q == LAST_WAY);

    // All outputs are registers updated on the state transition. The command
    // therefore stays frozen while a grant or ack is pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            way_q       <= '0;
            flushing_q  <= 1'b0;
            complete_q  <= 1'b0;
            array_req_q <= 1'b0;
            array_we_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flushReq) begin
                        state_q    <= S_DRAIN;
                        flushing_q <= 1'b1;
                        index_q    <= '0;
                        way_q      <= '0;
                    end
                end
                S_DRAIN: begin
                    // Outstanding misses could refill lines behind the walk.
                    if (!mshrBusy) begin
                        state_q     <= S_RD;
                        array_req_q <= 1'b1;
                        array_we_q  <= 1'b0;
                    end
                end
                S_RD: begin
                    if (arrayGrt) begin
                        state_q     <= S_RD_WAIT;
                        array_req_q <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    // The array read result is present only in this cycle.
                    if (arrayValidOut && arrayDirtyOut) begin
                        mem_addr_q <= {arrayTagOut, index_q, {OFFSET_BIT_WIDTH{1'b0}}};
                        mem_data_q <= arrayDataOut;
                        mem_req_q  <= 1'b1;
                        state_q    <= S_WB_REQ;
                    end else if (arrayValidOut) begin
                        array_req_q <= 1'b1;
                        array_we_q  <= 1'b1;
                        state_q     <= S_INV;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_WB_REQ: begin
                    if (memReqAck) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WB_WAIT;
                    end
                end
                S_WB_WAIT: begin
                    // memWriteDone is looked at only after the ack cycle.
                    if (memWriteDone) begin
                        array_req_q <= 1'b1;
                        array_we_q  <= 1'b1;
                        state_q     <= S_INV;
                    end
                end
                S_INV: begin
                    if (arrayGrt) begin
                        array_req_q <= 1'b0;
                        array_we_q  <= 1'b0;
                        state_q     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // The counters stop on the last line and never wrap.
                    if (last_line) begin
                        complete_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        if (way_q == LAST_WAY) begin
                            way_q   <= '0;
                            index_q <= index_q + INDEX_ONE;
                        end else begin
                            way_q <= way_q + WAY_ONE;
                        end
                        array_req_q <= 1'b1;
                        array_we_q  <= 1'b0;
                        state_q     <= S_RD;
                    end
                end
                S_DONE: begin
                    complete_q <= 1'b0;
                    flushing_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dcFlushing      = flushing_q;
    assign dcFlushComplete = complete_q;
    assign arrayReq        = array_req_q;
    assign arrayWE         = array_we_q;
    assign arrayIndex      = index_q;
    assign arrayWay        = way_q;
    assign memReq          = mem_req_q;
    assign memAddr         = mem_addr_q;
    assign memData         = mem_data_q;

endmodule
